// File: rtl/adc_capture_ctrl_if.sv
// Write port toward the downstream 64-bit capture FIFO.
// Latency: none, this is only a signal bundle.
// Backpressure: fifo_full is driven by the FIFO; when it is high, a write presented in that cycle is lost.
interface adc_capture_ctrl_if;
    logic [63:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;

    modport master (output fifo_din, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC capture: arm, wait for trigger, then pack 8 samples into each 64-bit FIFO word.
// Latency: the trigger sample at cycle t gives the first fifo_wr_en at t+8. Later words follow every 8 cycles.
// Backpressure: packing never stalls. A word whose emit cycle sees fifo_full is dropped and sets sticky overflow.
module adc_capture_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             adc_clk,
    input  logic             rst,
    input  logic [7:0]       adc_data,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig_mode,
    input  logic [7:0]       trig_level,
    input  logic [LEN_W-1:0] capture_len,
    adc_capture_ctrl_if.master fifo,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [LEN_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [7:0]       prev_q;     // adc_data from the previous cycle, used for edge detection
    logic [2:0]       byte_idx;   // slot that the current sample is loaded into
    logic [55:0]      word_q;     // bytes 0..6 of the word being built; byte 7 arrives on the emit edge
    logic [63:0]      din_q;
    logic             emit_vld;   // a completed word is presented in this cycle
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] emit_num;   // words emitted so far, whether written or dropped
    logic             trig_hit;
    logic             last_emit;

    assign trig_hit  = !trig_mode || ((prev_q < trig_level) && (adc_data >= trig_level));
    assign last_emit = emit_vld && ((emit_num + ONE) == len_q);

    // Abort and reset take priority over a pending write in the same cycle.
    assign fifo.fifo_din   = din_q;
    assign fifo.fifo_wr_en = emit_vld && !fifo.fifo_full && !abort && !rst;

    // Capture sequencer, byte packer and status counters.
    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state    <= S_IDLE;
            prev_q   <= 8'd0;
            byte_idx <= 3'd0;
            word_q   <= 56'd0;
            din_q    <= 64'd0;
            emit_vld <= 1'b0;
            len_q    <= '0;
            emit_num <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            word_cnt <= '0;
        end else begin
            prev_q   <= adc_data;
            emit_vld <= 1'b0;
            if (abort) begin
                // The partial word is discarded. The counters keep what the aborted run achieved.
                state    <= S_IDLE;
                busy     <= 1'b0;
                done     <= 1'b0;
                byte_idx <= 3'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        done <= 1'b0;
                        if (arm && (capture_len != '0)) begin
                            len_q    <= capture_len;
                            overflow <= 1'b0;
                            word_cnt <= '0;
                            emit_num <= '0;
                            byte_idx <= 3'd0;
                            busy     <= 1'b1;
                            state    <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (trig_hit) begin
                            word_q[7:0] <= adc_data;
                            byte_idx    <= 3'd1;
                            state       <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (byte_idx == 3'd7) begin
                            din_q    <= {adc_data, word_q};
                            emit_vld <= 1'b1;
                        end else begin
                            word_q[{byte_idx, 3'b000} +: 8] <= adc_data;
                        end
                        byte_idx <= byte_idx + 3'd1;
                        if (emit_vld) begin
                            emit_num <= emit_num + ONE;
                            if (fifo.fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                word_cnt <= word_cnt + ONE;
                            end
                            if (last_emit) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomised and directed bench for adc_capture_ctrl against a per-capture reference model.
// The model finds the trigger cycle in the sample stream and derives every emit cycle, word, and status from it.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_adc_capture_ctrl;
    localparam int LEN_W = 16;
    localparam int MAXC  = 256;

    logic             adc_clk = 1'b0;
    logic             rst;
    logic [7:0]       adc_data;
    logic             arm;
    logic             abort;
    logic             trig_mode;
    logic [7:0]       trig_level;
    logic [LEN_W-1:0] capture_len;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [LEN_W-1:0] word_cnt;

    adc_capture_ctrl_if fifo_if ();

    adc_capture_ctrl #(.LEN_W(LEN_W)) dut (
        .adc_clk    (adc_clk),
        .rst        (rst),
        .adc_data   (adc_data),
        .arm        (arm),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .capture_len(capture_len),
        .fifo       (fifo_if),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_cnt   (word_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [7:0] smp [MAXC];
    logic       ful [MAXC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs after the rising edge, then wait for the falling edge so the caller can sample.
    task automatic step(input logic a_arm, input logic a_abort, input logic [LEN_W-1:0] a_len,
                        input logic a_full, input logic [7:0] a_dat);
        @(posedge adc_clk);
        #1;
        arm               = a_arm;
        abort             = a_abort;
        capture_len       = a_len;
        fifo_if.fifo_full = a_full;
        adc_data          = a_dat;
        @(negedge adc_clk);
    endtask

    task automatic fill_rand(input int full_pct);
        for (int i = 0; i < MAXC; i++) begin
            smp[i] = 8'($urandom);
            ful[i] = ($urandom_range(0, 99) < full_pct);
        end
    endtask

    // smp[0] is the arm cycle. The ramp 0,1,2,... starts at cycle 1.
    task automatic fill_ramp();
        for (int i = 0; i < MAXC; i++) begin
            smp[i] = (i == 0) ? 8'hFF : 8'(i - 1);
            ful[i] = 1'b0;
        end
    endtask

    // Arm in cycle 0, then play smp/ful. abort_at: -1 none, 0 random, >0 fixed cycle.
    task automatic run_capture(input bit mode, input logic [7:0] lvl, input int len,
                               input int abort_at, input bit stray);
        int         t;
        int         done_c;
        int         a;
        int         last;
        int         wr_cnt;
        bit         ovf;
        bit         cut;
        bit         emit;
        bit         exp_wr;
        int         k;
        int         stop_c;
        logic       s_arm;
        logic [LEN_W-1:0] s_len;
        logic [63:0] w;
        trig_mode  = mode;
        trig_level = lvl;
        t = -1;
        for (int c = 1; c <= 60; c++) begin
            if (!mode || (smp[c-1] < lvl && smp[c] >= lvl)) begin
                t = c;
                break;
            end
        end
        done_c = (t >= 0) ? t + 8 * len + 1 : -1;
        a = -1;
        if (t < 0) begin
            a = 70;
        end else if (abort_at > 0) begin
            a = abort_at;
        end else if (abort_at == 0) begin
            do a = $urandom_range(1, done_c - 1); while (a > t && (a - t) % 8 == 0);
        end
        last   = (a >= 0) ? a + 3 : done_c + 3;
        stop_c = (a >= 0) ? a : done_c;
        wr_cnt = 0;
        ovf    = 1'b0;
        for (int c = 0; c <= last; c++) begin
            s_arm = (c == 0) || (stray && c <= stop_c && $urandom_range(0, 5) == 0);
            s_len = (c == 0) ? LEN_W'(len) : LEN_W'($urandom);
            step(s_arm, (c == a), s_len, ful[c], smp[c]);
            cut  = (a >= 0 && c > a);
            emit = (t >= 0 && c > t && (c - t) % 8 == 0 && (c - t) / 8 <= len && !(a >= 0 && c >= a));
            exp_wr = emit && !ful[c];
            chk("wr_en", 64'(fifo_if.fifo_wr_en), 64'(exp_wr));
            if (exp_wr) begin
                k = (c - t) / 8;
                for (int j = 0; j < 8; j++) w[8*j +: 8] = smp[t + 8 * (k - 1) + j];
                chk("din", fifo_if.fifo_din, w);
            end
            chk("busy", 64'(busy), 64'(!cut && c >= 1 && (done_c < 0 || c < done_c)));
            chk("done", 64'(done), 64'(!cut && c == done_c));
            if (c >= 1) begin
                chk("word_cnt", 64'(word_cnt), 64'(wr_cnt));
                chk("overflow", 64'(overflow), 64'(ovf));
            end
            if (emit) begin
                if (ful[c]) ovf = 1'b1;
                else        wr_cnt++;
            end
        end
    endtask

    initial begin
        rst               = 1'b1;
        arm               = 1'b0;
        abort             = 1'b0;
        trig_mode         = 1'b0;
        trig_level        = 8'd0;
        capture_len       = '0;
        adc_data          = 8'd0;
        fifo_if.fifo_full = 1'b0;
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 8'h00);
        chk("rst_din", fifo_if.fifo_din, 64'd0);
        chk("rst_wr", 64'(fifo_if.fifo_wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0;

        // Immediate trigger, ramp data, 2 words.
        fill_ramp();
        run_capture(1'b0, 8'h00, 2, -1, 1'b0);

        // Level trigger on 0x7E,0x7F,0x80; the flat 0x80 that follows must not retrigger.
        for (int i = 0; i < MAXC; i++) begin
            smp[i] = (i == 0) ? 8'h7E : (i == 1) ? 8'h7F : 8'h80;
            ful[i] = 1'b0;
        end
        run_capture(1'b1, 8'h80, 2, -1, 1'b0);
        for (int i = 0; i < MAXC; i++) smp[i] = 8'h80;
        run_capture(1'b1, 8'h80, 2, -1, 1'b0);

        // FIFO full during the middle word's emit cycle.
        fill_ramp();
        ful[17] = 1'b1;
        run_capture(1'b0, 8'h00, 3, -1, 1'b0);

        // Abort 4 cycles into CAPTURE, then a normal re-arm.
        fill_ramp();
        run_capture(1'b0, 8'h00, 4, 5, 1'b0);
        run_capture(1'b0, 8'h00, 1, -1, 1'b0);

        // An arm with a zero length is ignored.
        step(1'b1, 1'b0, '0, 1'b0, 8'h11);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, '0, 1'b0, 8'h22);
            chk("len0_busy", 64'(busy), 64'd0);
            chk("len0_done", 64'(done), 64'd0);
        end

        // When arm and abort arrive in the same cycle, abort wins.
        step(1'b1, 1'b1, 16'd2, 1'b0, 8'h33);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, '0, 1'b0, 8'(c));
            chk("armabort_busy", 64'(busy), 64'd0);
            chk("armabort_wr", 64'(fifo_if.fifo_wr_en), 64'd0);
        end

        // Reset mid-capture after one dropped word and in the cycle of the next write.
        fill_ramp();
        ful[9] = 1'b1;
        trig_mode = 1'b0;
        for (int c = 0; c <= 17; c++) step((c == 0), 1'b0, 16'd4, ful[c], smp[c]);
        chk("pre_rst_wr", 64'(fifo_if.fifo_wr_en), 64'd1);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        rst = 1'b1;
        step(1'b0, 1'b0, 16'd4, 1'b0, smp[18]);
        chk("mid_rst_din", fifo_if.fifo_din, 64'd0);
        chk("mid_rst_wr", 64'(fifo_if.fifo_wr_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0;
        for (int c = 19; c <= 30; c++) begin
            step(1'b0, 1'b0, 16'd4, 1'b0, smp[c]);
            chk("post_rst_wr", 64'(fifo_if.fifo_wr_en), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end

        // Randomised captures with stray arms, random lengths, backpressure and aborts.
        for (int it = 0; it < 24; it++) begin
            fill_rand((it % 3 == 0) ? 30 : 0);
            run_capture(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 20),
                        ($urandom_range(0, 3) == 0) ? 0 : -1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
